// File: rtl/ms_scan_if.sv
// Channel, control and result signals shared between a source/consumer (master)
// and the ms_scan multiplexer (slave).
interface ms_scan_if #(
    parameter int W  = 4,
    parameter int N  = 3,
    parameter int AW = 2
);
    logic [N*W-1:0] x;
    logic [AW-1:0]  adr;
    logic           mode;
    logic           en;
    logic [W-1:0]   y;
    logic [N-1:0]   sel;
    logic [AW-1:0]  ch;
    logic           stb;
    logic           err;

    modport master (
        output x, adr, mode, en,
        input  y, sel, ch, stb, err
    );

    modport slave (
        input  x, adr, mode, en,
        output y, sel, ch, stb, err
    );
endinterface

// File: rtl/ms_scan.sv
// Registered N-channel W-bit multiplexer: address-selected in manual mode,
// time-division scanner with a programmable dwell in auto mode.
module ms_scan #(
    parameter int W   = 4,
    parameter int N   = 3,
    parameter int AW  = 2,
    parameter int DIV = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    ms_scan_if.slave  bus
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [AW-1:0] TOP  = AW'(N - 1);

    logic [W-1:0]  r_y;
    logic [N-1:0]  r_sel;
    logic [AW-1:0] r_ch;
    logic [CW-1:0] r_cnt;
    logic          r_stb;
    logic          r_err;

    logic [AW-1:0] w_idx;
    logic [W-1:0]  w_data;
    logic [N-1:0]  w_oneHot;
    logic          w_adrValid;
    logic [AW-1:0] w_chNext;

    // Indices N..2^AW-1 match no channel, so they select zero data and an empty one-hot.
    always_comb begin
        w_idx      = bus.mode ? r_ch : bus.adr;
        w_data     = '0;
        w_oneHot   = '0;
        w_adrValid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (w_idx == AW'(k)) begin
                w_data      = bus.x[k*W +: W];
                w_oneHot[k] = 1'b1;
            end
            if (bus.adr == AW'(k)) begin
                w_adrValid = 1'b1;
            end
        end
    end

    assign w_chNext = (r_ch == TOP) ? '0 : r_ch + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_sel <= '0;
            r_ch  <= '0;
            r_cnt <= '0;
            r_stb <= 1'b0;
            r_err <= 1'b0;
        end else if (!bus.en) begin
            r_stb <= 1'b0;
        end else begin
            r_y   <= w_data;
            r_sel <= w_oneHot;
            r_err <= !bus.mode && !w_adrValid;
            if (!bus.mode) begin
                r_cnt <= '0;
                r_stb <= 1'b0;
                if (w_adrValid) begin
                    r_ch <= bus.adr;
                end
            end else if (r_cnt == LAST) begin
                r_cnt <= '0;
                r_ch  <= w_chNext;
                r_stb <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_stb <= 1'b0;
            end
        end
    end

    assign bus.y   = r_y;
    assign bus.sel = r_sel;
    assign bus.ch  = r_ch;
    assign bus.stb = r_stb;
    assign bus.err = r_err;
endmodule
